// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension stage feeding a two-entry skid buffer.
// The extended result is formed combinationally from in_imm/in_mode and is
// captured at input transfer. The buffer is a main output register plus one
// skid register, so in_ready can be a pure register (NOT skid_valid) with no
// combinational path from out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once out_valid is 1, out_valid and out_data hold until a transfer
// occurs. in_ready is registered, and in_valid may be raised or dropped freely.
//
// Legal parameter range: OUT_W >= IN_W+2 and IN_W+BR_SH <= OUT_W.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int BR_SH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      out_cnt
);

  typedef enum logic [1:0] {
    MODE_ZEXT   = 2'b00,
    MODE_SEXT   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_t;

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] ext_res;

  logic             main_valid;
  logic             skid_valid;
  logic [OUT_W-1:0] main_data;
  logic [OUT_W-1:0] skid_data;

  logic             main_valid_nxt;
  logic             skid_valid_nxt;
  logic             load_main_new;
  logic             load_main_skid;
  logic             load_skid;

  logic             in_fire;
  logic             out_fire;

  // Input presented during a flush cycle is dropped along with the buffer.
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Extension of the raw immediate according to the selected mode.
  always_comb begin
    sext_val = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    ext_res  = '0;
    case (mode_t'(in_mode))
      MODE_ZEXT:   ext_res = {{PAD_W{1'b0}}, in_imm};
      MODE_SEXT:   ext_res = sext_val;
      MODE_UPPER:  ext_res = {in_imm, {PAD_W{1'b0}}};
      MODE_BRANCH: ext_res = sext_val << BR_SH;
      default:     ext_res = '0;
    endcase
  end

  // Buffer control: decide where a new result lands and how valid bits move.
  // A skid entry only exists while in_ready is low, so an input transfer never
  // coincides with a skid-to-main move.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        load_main_skid = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (in_fire) begin
        // Replace the draining entry in place: no bubble.
        load_main_new  = 1'b1;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        load_main_new  = 1'b1;
        main_valid_nxt = 1'b1;
      end else begin
        load_skid      = 1'b1;
        skid_valid_nxt = 1'b1;
      end
    end
  end

  // Valid bits and the registered in_ready; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= ~skid_valid_nxt;
    end
  end

  // Main output register; reset to zero so out_data reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end else if (load_main_new) begin
      main_data <= ext_res;
    end
  end

  // Skid data register; its contents are meaningless while skid_valid is 0.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data <= ext_res;
    end
  end

  // Count of downstream transfers, including one that happens during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Testbench for ext_pipe (IN_W=16, OUT_W=32, BR_SH=2): directed vectors,
// expected results queued at input acceptance and checked by a monitor.
module tb_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_cnt;

  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt;
  int          checks;
  int          errors;
  int          cyc;
  int          mon_n;
  int          mon_first;
  int          mon_last;

  ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] r;
    case (mode)
      2'b00:   r = {16'h0000, imm};
      2'b01:   r = {{16{imm[15]}}, imm};
      2'b10:   r = {imm, 16'h0000};
      default: r = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] imm, input logic [1:0] mode);
    int  budget;
    bit  done;
    budget   = 200;
    done     = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    while (!done && budget > 0) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(imm, mode));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid = 1'b0;
    if (!done) timeout("send");
  endtask

  task automatic stream(input int n, input logic [15:0] start, input logic [1:0] mode);
    int budget;
    int got;
    bit acc;
    budget   = n + 100;
    got      = 0;
    in_valid = 1'b1;
    in_imm   = start;
    in_mode  = mode;
    while (got < n && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(model(in_imm, mode));
      @(posedge clk);
      #1;
      if (acc) begin
        got++;
        in_imm = in_imm + 16'd1;
      end
      budget--;
    end
    in_valid = 1'b0;
    if (got < n) timeout("stream");
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) timeout("drain");
  endtask

  // Asynchronous reset applied between edges; model state cleared with it.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
    #4;
    rst_n     = 1'b1;
    mon_n     = 0;
    mon_first = 0;
    mon_last  = 0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with no expected entry", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
        exp_cnt = exp_cnt + 16'd1;
        if (mon_n == 0) mon_first = cyc;
        mon_last = cyc;
        mon_n++;
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    mon_n     = 0;
    mon_first = 0;
    mon_last  = 0;
    exp_cnt   = 16'd0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = 16'h0000;
    in_mode   = 2'b00;
    out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_cnt", {16'd0, out_cnt}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    #13;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Modes with 1-cycle latency, output drains every cycle
    out_ready = 1'b1;
    send(16'h8000, 2'b00); chk("lat_zext",   out_data, 32'h00008000);
    send(16'h8000, 2'b01); chk("lat_sext",   out_data, 32'hFFFF8000);
    send(16'h8000, 2'b10); chk("lat_upper",  out_data, 32'h80000000);
    send(16'h8000, 2'b11); chk("lat_branch", out_data, 32'hFFFE0000);
    send(16'h7FFF, 2'b01); chk("lat_sext_pos", out_data, 32'h00007FFF);
    send(16'h1234, 2'b10); chk("lat_upper2", out_data, 32'h12340000);
    send(16'h0001, 2'b11); chk("lat_branch_pos", out_data, 32'h00000004);
    send(16'hFFFF, 2'b00); chk("lat_zext_ff", out_data, 32'h0000FFFF);
    drain();
    chk("cnt_modes", {16'd0, out_cnt}, {16'd0, exp_cnt});
    chk("cnt_modes_abs", {16'd0, out_cnt}, 32'd8);

    // Backpressure: two entries fill, then drain in order
    do_reset();
    out_ready = 1'b0;
    send(16'hAAAA, 2'b00);
    send(16'h5555, 2'b01);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_data_a", out_data, 32'h0000AAAA);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_data", out_data, 32'h0000AAAA);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second", out_data, 32'h00005555);
    drain();
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_out_cnt", {16'd0, out_cnt}, 32'd2);

    // Streaming: no bubbles after the first result
    do_reset();
    out_ready = 1'b1;
    stream(10, 16'h0100, 2'b01);
    drain();
    chk("stream_count", mon_n, 32'd10);
    chk("stream_no_bubble", mon_last - mon_first, 32'd9);
    chk("stream_out_cnt", {16'd0, out_cnt}, 32'd10);

    // Flush with both entries full
    do_reset();
    out_ready = 1'b0;
    send(16'h1111, 2'b00);
    send(16'h2222, 2'b00);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_cnt", {16'd0, out_cnt}, 32'd0);
    out_ready = 1'b1;
    send(16'h3333, 2'b10);
    chk("post_flush_data", out_data, 32'h33330000);
    drain();
    chk("post_flush_cnt", {16'd0, out_cnt}, 32'd1);

    // Asynchronous reset while full
    do_reset();
    out_ready = 1'b1;
    send(16'h0042, 2'b00);
    drain();
    out_ready = 1'b0;
    send(16'hBEEF, 2'b01);
    send(16'hCAFE, 2'b01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_out_cnt", {16'd0, out_cnt}, 32'd0);
    chk("async_out_data", out_data, 32'd0);
    exp_q.delete();
    exp_cnt = 16'd0;
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h0F0F, 2'b11);
    chk("async_after_data", out_data, 32'h00003C3C);
    drain();
    chk("async_after_cnt", {16'd0, out_cnt}, 32'd1);

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    stream(65535, 16'h0000, 2'b00);
    drain();
    chk("cnt_max", {16'd0, out_cnt}, 32'd65535);
    send(16'h0007, 2'b00);
    drain();
    chk("cnt_wrap", {16'd0, out_cnt}, 32'd0);
    chk("cnt_wrap_model", {16'd0, out_cnt}, {16'd0, exp_cnt});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
